// File: rtl/npu_pkg.sv
// Shared NPU constants and the skew feeder's state encoding.
package npu_pkg;

   localparam int NPU_LANES  = 8;
   localparam int NPU_ELEM_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } npu_state_e;

endpackage

// File: rtl/npu_skew_lane.sv
// Enable-gated delay line of DEPTH stages carrying one lane element and its valid bit.
module npu_skew_lane #(
   parameter int DEPTH  = 1,
   parameter int ELEM_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [ELEM_W-1:0] data_i,
   input  logic              vld_i,
   output logic [ELEM_W-1:0] data_o,
   output logic              vld_o
);

   logic [DEPTH-1:0][ELEM_W-1:0] data_q;
   logic [DEPTH-1:0]             vld_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         vld_q  <= '0;
      end else if (en_i) begin
         data_q[0] <= data_i;
         vld_q[0]  <= vld_i;
         for (int k = 1; k < DEPTH; k++) begin
            data_q[k] <= data_q[k-1];
            vld_q[k]  <= vld_q[k-1];
         end
      end
   end

   assign data_o = data_q[DEPTH-1];
   assign vld_o  = vld_q[DEPTH-1];

endmodule

// File: rtl/npu_skew_feeder.sv
// Skews activation rows onto the PE array west edge: lane i delayed i+1 advances.
// Optional NPU_SKEW_ZERO_PAD_EN zeroes the bytes of lanes whose valid bit is low.
module npu_skew_feeder
   import npu_pkg::*;
#(
   parameter int LANES  = NPU_LANES,
   parameter int ELEM_W = NPU_ELEM_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LANES*ELEM_W-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sop,
   input  logic                    in_eop,
   output logic [LANES*ELEM_W-1:0] out_data,
   output logic [LANES-1:0]        out_lane_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    tile_done,
   output logic                    proto_err
);

   npu_state_e state_q, state_d;
   logic       proto_err_q, proto_err_d;
   logic [LANES-1:0] eop_q, eop_d;
   logic       accept;

   logic [LANES-1:0][ELEM_W-1:0] lane_data;
   logic [LANES-1:0]             lane_vld;

   assign in_ready  = out_ready && (state_q != DRAIN);
   assign accept    = in_valid && in_ready;
   assign tile_done = eop_q[LANES-1] && out_ready;
   assign busy      = (state_q != IDLE);
   assign proto_err = proto_err_q;

   // The eop marker rides alongside the longest (last) lane's delay line.
   assign eop_d = {eop_q[LANES-2:0], accept && in_eop};

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      npu_skew_lane #(
         .DEPTH  (g + 1),
         .ELEM_W (ELEM_W)
      ) u_lane (
         .clk_i  (clk),
         .rst_i  (rst),
         .en_i   (out_ready),
         .data_i (in_data[g*ELEM_W +: ELEM_W]),
         .vld_i  (accept),
         .data_o (lane_data[g]),
         .vld_o  (lane_vld[g])
      );
`ifdef NPU_SKEW_ZERO_PAD_EN
      assign out_data[g*ELEM_W +: ELEM_W] = lane_vld[g] ? lane_data[g] : '0;
`else
      assign out_data[g*ELEM_W +: ELEM_W] = lane_data[g];
`endif
   end

   assign out_lane_valid = lane_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         proto_err_q <= 1'b0;
         eop_q       <= '0;
      end else begin
         state_q     <= state_d;
         proto_err_q <= proto_err_d;
         if (out_ready) eop_q <= eop_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      proto_err_d = proto_err_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = in_eop ? DRAIN : STREAM;
            if (!in_sop) proto_err_d = 1'b1;
         end
         STREAM: if (accept) begin
            if (in_eop) state_d = DRAIN;
            if (in_sop) proto_err_d = 1'b1;
         end
         DRAIN: if (tile_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/npu_skew_feeder.md
NPU_SKEW_FEEDER -- requirements
Module: npu_skew_feeder

Interface
REQ-001 SHALL have parameter LANES, default 8, number of int8 lanes per beat (8 x 8 = 64-bit beat).
REQ-002 SHALL have parameter ELEM_W, default 8, bits per lane element.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  64  activation row from the stream controller; lane i = bits [8i+7:8i].
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1, the upstream valid/ready handshake.
REQ-007 SHALL have ports in_sop input 1 and in_eop input 1, first and last row of the current tile.
REQ-008 SHALL have port out_data  output  64  skewed lane data to the PE array's west edge.
REQ-009 SHALL have port out_lane_valid  output  8  per-lane valid of out_data.
REQ-010 SHALL have port out_ready  input  1  global advance enable from the PE array.
REQ-011 SHALL have ports busy output 1 (state != IDLE), tile_done output 1 (1-cycle pulse) and proto_err output 1 (sticky).

Function
REQ-012 SHALL define an advance as any cycle with out_ready=1; all skew registers shift only on an advance, and hold otherwise.
REQ-013 SHALL delay lane i by exactly i+1 advances from acceptance (lane 0 = 1, lane 7 = 8).
REQ-014 SHALL accept a beat when in_valid && in_ready; in_ready = out_ready && state != DRAIN (combinational).
REQ-015 SHALL inject a bubble (lane valid 0) into the skew on an advance with no accepted beat.
REQ-016 SHALL implement states IDLE, STREAM, DRAIN:
  - IDLE -> STREAM on an accepted beat without eop; IDLE -> DRAIN on an accepted beat with eop.
  - STREAM -> DRAIN on an accepted beat with in_eop=1.
  - DRAIN -> IDLE on the advance where the eop marker leaves lane 7.
REQ-017 SHALL carry a 1-bit eop marker alongside lane 7's delay line; tile_done = marker at lane-7 output && out_ready.
REQ-018 SHALL treat in_sop=in_eop=1 on the same beat as a one-row tile: go straight to DRAIN and pulse tile_done 8 advances later.
REQ-019 SHALL set proto_err when a beat is accepted in IDLE without in_sop, or in STREAM with in_sop; the beat is still processed normally.
REQ-020 SHALL keep in_ready low for all of DRAIN; new tile rows wait until IDLE.
REQ-021 SHALL keep out_data and out_lane_valid stable while out_ready=0.

Reset
REQ-022 SHALL clear on rst: all skew data to 0, out_lane_valid=0, eop markers=0, state=IDLE, tile_done=0, proto_err=0, busy=0.
REQ-023 SHALL abandon any in-flight tile on rst asserted mid-STREAM/DRAIN, with no tile_done for that tile.

Configuration
REQ-024 SHALL, with NPU_SKEW_ZERO_PAD_EN defined, force the out_data bytes of lanes whose out_lane_valid bit is 0 to 8'h00.
REQ-025 SHALL, without NPU_SKEW_ZERO_PAD_EN, pass the invalid-lane bytes unmasked; their value is don't-care to the consumer.

Structure
REQ-026 SHALL take NPU_LANES, NPU_ELEM_W and the 2-bit state encoding (IDLE=0, STREAM=1, DRAIN=2) from shared package npu_pkg.
REQ-027 SHALL build each lane from sub-module npu_skew_lane (parameter DEPTH, an enable-gated delay line carrying data and a valid bit), instantiated with DEPTH=i+1.

Verification
REQ-028 SHALL cover a single beat 64'h0807060504030201 with sop+eop and out_ready=1: lane i shows 8'h(i+1) with a valid bit exactly i+1 cycles after acceptance, then tile_done at cycle 8 and busy falling at cycle 9.
REQ-029 SHALL cover an 8-row tile streamed back-to-back: out_lane_valid reads 01,03,07,0F,1F,3F,7F,FF,FE,...,80,00 on successive cycles, with one tile_done.
REQ-030 SHALL cover out_ready held low for 5 cycles mid-tile: outputs frozen, in_ready=0, no beat lost or duplicated, and the result matches the no-stall run.
REQ-031 SHALL cover in_valid pulsed during DRAIN: in_ready=0 and no acceptance until IDLE.
REQ-032 SHALL cover a first beat without sop: proto_err=1 stays set until rst and the data is still emitted. Also rst mid-DRAIN: all outputs 0 next cycle and no tile_done.
REQ-033 SHALL run with NPU_SKEW_ZERO_PAD_EN defined: bytes on lanes with valid=0 read 8'h00 throughout the scenarios above.
